regfile_wb_arbiter: RTL



---
 rtl/regfile_wb_arbiter.sv | 95 +++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between execute
// writeback and load return; registers the winner onto we3/a3/wd3.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stall,
  input  logic                       ex_valid,
  output logic                       ex_ready,
  input  logic [ADDR_W-1:0]          ex_addr,
  input  logic [DATA_W-1:0]          ex_data,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [ADDR_W-1:0]          ld_addr,
  input  logic [DATA_W-1:0]          ld_data,
  output logic                       we3,
  output logic [ADDR_W-1:0]          a3,
  output logic [DATA_W-1:0]          wd3,
  output logic [(1<<ADDR_W)-1:0]     pend_mask,
  output logic [CNT_W-1:0]           wr_count
);

  localparam int NREG = 1 << ADDR_W;

  // Handshake: a transfer happens on an edge where valid && ready; a requester
  // holds valid/addr/data stable until ready and never withdraws valid early.
  // ready is purely combinational and at most one of the two is ever set.

  // rr_ptr: 0 = ex wins a tie, 1 = ld wins a tie
  logic              rr_ptr;
  logic              grant_ex;
  logic              grant_ld;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  always_comb begin
    grant_ex = 1'b0;
    grant_ld = 1'b0;
    if (rst_n && !stall) begin
      if (ex_valid && (!ld_valid || !rr_ptr)) grant_ex = 1'b1;
      else if (ld_valid)                      grant_ld = 1'b1;
    end
  end

  assign ex_ready = grant_ex;
  assign ld_ready = grant_ld;
  assign win_addr = grant_ld ? ld_addr : ex_addr;
  assign win_data = grant_ld ? ld_data : ex_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (grant_ex) begin
      rr_ptr <= 1'b1;
    end else if (grant_ld) begin
      rr_ptr <= 1'b0;
    end
  end

  // Writes to x0 are accepted but never reach the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we3 <= 1'b0;
      a3  <= '0;
      wd3 <= '0;
    end else if (grant_ex || grant_ld) begin
      we3 <= (win_addr != '0);
      a3  <= win_addr;
      wd3 <= win_data;
    end else begin
      we3 <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count <= '0;
    end else if (we3) begin
      wr_count <= wr_count + 1'b1;
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 1; i < NREG; i++) begin
      pend_mask[i] = (ex_valid && (ex_addr == ADDR_W'(i))) ||
                     (ld_valid && (ld_addr == ADDR_W'(i))) ||
                     (we3      && (a3      == ADDR_W'(i)));
    end
  end

endmodule
